// File: rtl/posit_fmau_pkg.sv
// Shared definitions for the Posit FMAU exponent path.
// Contents:
//   mode_t      per-beat SIMD lane split (4xW/4, 2xW/2, 1xW, illegal)
//   slot_width  width of one packed output slot for a given lane count
package posit_fmau_pkg;

    typedef enum logic [1:0] {
        MODE_4X4  = 2'b00,
        MODE_2X8  = 2'b01,
        MODE_1X16 = 2'b10,
        MODE_ILL  = 2'b11
    } mode_t;

    function automatic int unsigned slot_width(input int unsigned out_w,
                                               input int unsigned lanes);
        return out_w / lanes;
    endfunction

endpackage

// File: rtl/exp_lane_add.sv
// One signed exponent lane adder: sum = a + b at LW+1 bits.
// Configuration macro: EXP_ADD_SAT_EN clamps the sum to the LW-bit signed
// range and raises ovf when a clamp occurred; otherwise the sum is full
// precision and ovf is 0.
// Ports:
//   a, b  in   LW     two's-complement lane operands
//   sum   out  LW+1   lane sum (clamped value still carried at LW+1 bits)
//   ovf   out  1      clamp occurred
module exp_lane_add #(
    parameter int unsigned LW = 4
) (
    input  logic [LW-1:0] a,
    input  logic [LW-1:0] b,
    output logic [LW:0]   sum,
    output logic          ovf
);

    logic [LW:0] raw;

    always_comb begin
        raw = {a[LW-1], a} + {b[LW-1], b};
    end

`ifdef EXP_ADD_SAT_EN
    // The sum left the LW-bit range exactly when its top two bits disagree;
    // the top bit then tells which rail to clamp to.
    always_comb begin
        ovf = raw[LW] ^ raw[LW-1];
        sum = raw;
        if (ovf) begin
            if (raw[LW]) sum = {2'b11, {(LW-1){1'b0}}};
            else         sum = {2'b00, {(LW-1){1'b1}}};
        end
    end
`else
    always_comb begin
        sum = raw;
        ovf = 1'b0;
    end
`endif

endmodule

// File: rtl/exp_adder_pipe.sv
// Two-stage handshaked SIMD exponent adder: E = A+B, F = C+D per beat.
// Configuration macro: EXP_ADD_SAT_EN (per-lane saturation + ovf flags).
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid / in_ready   upstream handshake
//   mode                  00 4xW/4, 01 2xW/2, 10 1xW, 11 illegal
//   exp_a..exp_d          packed lane operands
//   out_valid / out_ready downstream handshake
//   exp_e, exp_f          packed sums, lane k in slot k of OUT_W/n bits
//   ovf_e, ovf_f          per-lane clamp flags
//   mode_err              result beat carried mode 11
module exp_adder_pipe
    import posit_fmau_pkg::*;
#(
    parameter int unsigned W     = 16,
    parameter int unsigned OUT_W = W + W / 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [W-1:0]     exp_a,
    input  logic [W-1:0]     exp_b,
    input  logic [W-1:0]     exp_c,
    input  logic [W-1:0]     exp_d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] exp_e,
    output logic [OUT_W-1:0] exp_f,
    output logic [3:0]       ovf_e,
    output logic [3:0]       ovf_f,
    output logic             mode_err
);

    localparam int unsigned LW4 = W / 4;
    localparam int unsigned LW2 = W / 2;
    localparam int unsigned SW4 = slot_width(OUT_W, 4);
    localparam int unsigned SW2 = slot_width(OUT_W, 2);
    localparam int unsigned SW1 = slot_width(OUT_W, 1);

    logic         s1_valid;
    mode_t        s1_mode;
    logic [W-1:0] s1_a, s1_b, s1_c, s1_d;
    logic         s2_advance;

    always_comb begin
        s2_advance = !out_valid || out_ready;
        in_ready   = !s1_valid || s2_advance;
    end

    // Stage 1: operand capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_mode  <= MODE_4X4;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_c     <= '0;
            s1_d     <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_mode <= mode_t'(mode);
                s1_a    <= exp_a;
                s1_b    <= exp_b;
                s1_c    <= exp_c;
                s1_d    <= exp_d;
            end
        end
    end

    // All three lane splits are computed every cycle; the registered mode picks one.
    logic [4*SW4-1:0] e4, f4;
    logic [2*SW2-1:0] e2, f2;
    logic [SW1-1:0]   e1, f1;
    logic [3:0]       oe4, of4;
    logic [1:0]       oe2, of2;
    logic             oe1, of1;

    for (genvar i = 0; i < 4; i++) begin : g_l4
        logic [LW4:0] se, sf;
        exp_lane_add #(.LW(LW4)) u_e (
            .a(s1_a[i*LW4 +: LW4]), .b(s1_b[i*LW4 +: LW4]), .sum(se), .ovf(oe4[i]));
        exp_lane_add #(.LW(LW4)) u_f (
            .a(s1_c[i*LW4 +: LW4]), .b(s1_d[i*LW4 +: LW4]), .sum(sf), .ovf(of4[i]));
        always_comb begin
            e4[i*SW4 +: SW4] = SW4'(signed'(se));
            f4[i*SW4 +: SW4] = SW4'(signed'(sf));
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_l2
        logic [LW2:0] se, sf;
        exp_lane_add #(.LW(LW2)) u_e (
            .a(s1_a[i*LW2 +: LW2]), .b(s1_b[i*LW2 +: LW2]), .sum(se), .ovf(oe2[i]));
        exp_lane_add #(.LW(LW2)) u_f (
            .a(s1_c[i*LW2 +: LW2]), .b(s1_d[i*LW2 +: LW2]), .sum(sf), .ovf(of2[i]));
        always_comb begin
            e2[i*SW2 +: SW2] = SW2'(signed'(se));
            f2[i*SW2 +: SW2] = SW2'(signed'(sf));
        end
    end

    logic [W:0] se1, sf1;
    exp_lane_add #(.LW(W)) u_e1 (.a(s1_a), .b(s1_b), .sum(se1), .ovf(oe1));
    exp_lane_add #(.LW(W)) u_f1 (.a(s1_c), .b(s1_d), .sum(sf1), .ovf(of1));
    always_comb begin
        e1 = SW1'(signed'(se1));
        f1 = SW1'(signed'(sf1));
    end

    logic [OUT_W-1:0] nxt_e, nxt_f;
    logic [3:0]       nxt_oe, nxt_of;
    logic             nxt_err;

    always_comb begin
        nxt_e   = '0;
        nxt_f   = '0;
        nxt_oe  = '0;
        nxt_of  = '0;
        nxt_err = 1'b0;
        case (s1_mode)
            MODE_4X4: begin
                nxt_e  = OUT_W'(e4);
                nxt_f  = OUT_W'(f4);
                nxt_oe = oe4;
                nxt_of = of4;
            end
            MODE_2X8: begin
                nxt_e  = OUT_W'(e2);
                nxt_f  = OUT_W'(f2);
                nxt_oe = {2'b00, oe2};
                nxt_of = {2'b00, of2};
            end
            MODE_1X16: begin
                nxt_e  = OUT_W'(e1);
                nxt_f  = OUT_W'(f1);
                nxt_oe = {3'b000, oe1};
                nxt_of = {3'b000, of1};
            end
            default: nxt_err = 1'b1;
        endcase
    end

    // Stage 2: result register; holds while out_valid && !out_ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            exp_e     <= '0;
            exp_f     <= '0;
            ovf_e     <= '0;
            ovf_f     <= '0;
            mode_err  <= 1'b0;
        end else if (s2_advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                exp_e    <= nxt_e;
                exp_f    <= nxt_f;
                ovf_e    <= nxt_oe;
                ovf_f    <= nxt_of;
                mode_err <= nxt_err;
            end
        end
    end

endmodule
